// File: rtl/nibble_serial_adder.sv
`default_nettype none
// ============================================================================
// Module   : nibble_serial_adder (with ripple_carry_adder slice)
// Brief    : Wide-word adder that pushes 4*NIBBLES-bit operands through a
//            single 4-bit ripple-carry slice, one nibble per cycle, LSB first,
//            with valid/ready handshakes on both the operand and result sides.
// Revision : 1.0 - initial release
// ============================================================================

// 4-bit ripple-carry adder slice built from a chain of full adders.
module ripple_carry_adder (
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       Cin,
    output logic [3:0] Sum,
    output logic       Cout
);

    logic [4:0] carry;

    assign carry[0] = Cin;

    genvar i;
    for (i = 0; i < 4; i++) begin : g_bit
        assign Sum[i]     = A[i] ^ B[i] ^ carry[i];
        assign carry[i+1] = (A[i] & B[i]) | (carry[i] & (A[i] ^ B[i]));
    end

    assign Cout = carry[4];

endmodule

module nibble_serial_adder #(
    parameter int NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [4*NIBBLES-1:0]   a,
    input  logic [4*NIBBLES-1:0]   b,
    input  logic                   cin,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [4*NIBBLES-1:0]   sum,
    output logic                   cout,
    output logic                   ovf
);

    localparam int W  = 4 * NIBBLES;
    localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [CW-1:0] LAST_NIB = CW'(NIBBLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state;
    state_t         state_next;

    logic [W-1:0]   a_q;
    logic [W-1:0]   b_q;
    logic           carry_q;
    logic [CW-1:0]  cnt;
    logic [W-1:0]   work_q;

    logic [W-1:0]   a_shift;
    logic [W-1:0]   b_shift;
    logic [3:0]     rca_sum;
    logic           rca_cout;
    logic [W-1:0]   work_next;
    logic           accept;
    logic           last_nib;
    logic           ovf_next;

    // Current nibble k is brought down to bit 0 so the slice sees bits [4k+3:4k].
    assign a_shift  = a_q >> {cnt, 2'b00};
    assign b_shift  = b_q >> {cnt, 2'b00};
    assign accept   = in_valid & in_ready;
    assign last_nib = (cnt == LAST_NIB);

    ripple_carry_adder u_rca (
        .A    (a_shift[3:0]),
        .B    (b_shift[3:0]),
        .Cin  (carry_q),
        .Sum  (rca_sum),
        .Cout (rca_cout)
    );

    // Working sum with the slice result merged into nibble k.
    always_comb begin
        work_next = work_q;
        for (int i = 0; i < NIBBLES; i++) begin
            if (cnt == CW'(i)) begin
                work_next[4*i +: 4] = rca_sum;
            end
        end
    end

    // Signed overflow: like-signed operands producing a differently-signed sum.
    assign ovf_next = (a_q[W-1] == b_q[W-1]) & (work_next[W-1] != a_q[W-1]);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and handshake outputs decoded from state.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (last_nib) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Operand capture, per-nibble accumulation and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            cnt     <= '0;
            work_q  <= '0;
            sum     <= '0;
            cout    <= 1'b0;
            ovf     <= 1'b0;
        end else if (accept) begin
            a_q     <= a;
            b_q     <= b;
            carry_q <= cin;
            cnt     <= '0;
            work_q  <= '0;
        end else if (state == RUN) begin
            work_q  <= work_next;
            carry_q <= rca_cout;
            if (last_nib) begin
                // Results are published only here, so a reset mid-operation
                // can never leak a partial sum onto the outputs.
                cnt  <= '0;
                sum  <= work_next;
                cout <= rca_cout;
                ovf  <= ovf_next;
            end else begin
                cnt  <= cnt + CW'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_nibble_serial_adder.sv
`default_nettype none
// ============================================================================
// Module   : tb_nibble_serial_adder
// Brief    : Scoreboard bench for nibble_serial_adder (NIBBLES=4) using
//            directed operand vectors with hand-computed results.
// Revision : 1.0 - initial release
// ============================================================================
module tb_nibble_serial_adder;

    localparam int NIB = 4;
    localparam int W   = 4 * NIB;

    logic           clk = 1'b0;
    logic           rst_n = 1'b1;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [W-1:0]   a = '0;
    logic [W-1:0]   b = '0;
    logic           cin = 1'b0;
    logic           out_valid;
    logic           out_ready = 1'b1;
    logic [W-1:0]   sum;
    logic           cout;
    logic           ovf;

    typedef struct packed {
        logic [W-1:0] s;
        logic         c;
        logic         o;
    } exp_t;

    exp_t exp_q[$];

    int n_total = 0;
    int n_pass  = 0;

    nibble_serial_adder #(.NIBBLES(NIB)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Monitor: pops and compares whenever a result is being handed over.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_result", 32'(sum), 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("sum",  32'(sum),  32'(e.s));
                check("cout", 32'(cout), 32'(e.c));
                check("ovf",  32'(ovf),  32'(e.o));
            end
        end
    end

    // Present operands until accepted; optionally register the expected result.
    task automatic send(input logic [W-1:0] va, input logic [W-1:0] vb, input logic vc,
                        input logic push, input exp_t e);
        bit got;
        got      = 1'b0;
        a        = va;
        b        = vb;
        cin      = vc;
        in_valid = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (in_ready) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            check("accept_timeout", 32'd0, 32'd1);
        end
        @(posedge clk);
        if (got && push) exp_q.push_back(e);
        #1;
        in_valid = 1'b0;
    endtask

    // Wait until the scoreboard drains, then let the output handshake complete.
    task automatic wait_result();
        for (int i = 0; i < 40; i++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
        end
        if (exp_q.size() != 0) begin
            check("result_timeout", 32'(exp_q.size()), 32'd0);
            exp_q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [W-1:0] va;
        logic [W-1:0] vb;
        logic         vc;
        exp_t         e;
    } vec_t;

    vec_t vecs[5];

    initial begin
        vecs[0] = '{16'h0FFF, 16'h0001, 1'b0, '{16'h1000, 1'b0, 1'b0}};
        vecs[1] = '{16'hFFFF, 16'h0000, 1'b1, '{16'h0000, 1'b1, 1'b0}};
        vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, '{16'h8000, 1'b0, 1'b1}};
        vecs[3] = '{16'h8000, 16'h8000, 1'b0, '{16'h0000, 1'b1, 1'b1}};
        vecs[4] = '{16'h1234, 16'h1111, 1'b0, '{16'h2345, 1'b0, 1'b0}};

        // Reset asserted mid-cycle takes effect immediately.
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("rst_in_ready",  32'(in_ready),  32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_sum",       32'(sum),       32'h0);
        check("rst_cout",      32'(cout),      32'd0);
        check("rst_ovf",       32'(ovf),       32'd0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic add with latency check: valid after E0+4, not before.
        send(16'h0003, 16'h0003, 1'b0, 1'b1, '{16'h0006, 1'b0, 1'b0});
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("latency_early", 32'(out_valid), 32'd0);
        @(posedge clk);
        @(negedge clk);
        check("latency_on", 32'(out_valid), 32'd1);
        wait_result();

        // Carry ripple and overflow vectors.
        for (int i = 0; i < 4; i++) begin
            send(vecs[i].va, vecs[i].vb, vecs[i].vc, 1'b1, vecs[i].e);
            wait_result();
        end

        // Back-pressure: result held, extra operands ignored.
        out_ready = 1'b0;
        send(16'h0005, 16'h0002, 1'b1, 1'b1, '{16'h0008, 1'b0, 1'b0});
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid) break;
        end
        #1;
        a        = 16'h1111;
        b        = 16'h2222;
        cin      = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_sum",       32'(sum),       32'h0008);
            check("bp_in_ready",  32'(in_ready),  32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        wait_result();
        check("bp_back_idle", 32'(in_ready), 32'd1);
        send(vecs[4].va, vecs[4].vb, vecs[4].vc, 1'b1, vecs[4].e);
        wait_result();

        // Reset mid-RUN discards the operation.
        send(16'h1234, 16'h1111, 1'b0, 1'b0, '{16'h0, 1'b0, 1'b0});
        @(posedge clk);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_sum",       32'(sum),       32'h0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        begin
            int seen;
            seen = 0;
            for (int i = 0; i < 8; i++) begin
                @(negedge clk);
                if (out_valid) seen++;
            end
            check("midrst_no_valid", 32'(seen), 32'd0);
            check("midrst_sum_hold", 32'(sum),  32'h0);
        end
        @(posedge clk);
        #1;
        send(16'h000A, 16'h0001, 1'b0, 1'b1, '{16'h000B, 1'b0, 1'b0});
        wait_result();

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/nibble_serial_adder.md
# nibble_serial_adder

Multi-cycle wide-word adder built around the existing 4-bit `ripple_carry_adder`. It accepts two `4*NIBBLES`-bit operands over a valid/ready handshake. It then feeds them to one internal `ripple_carry_adder` instance one nibble per cycle, LSB nibble first, chaining each `Cout` into the next `Cin`. The assembled sum, carry-out and signed overflow are presented on a valid/ready output port. It sits between the operand source and the result consumer, acting as both feeder and consumer of the 4-bit adder stage.

## Interface
- `NIBBLES`, default 4: number of 4-bit slices; operand width `W = 4*NIBBLES`; legal range 1..16.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  operand request.
- `in_ready`  out  1  block can accept operands.
- `a`  in  W  operand A; sampled only on the input handshake.
- `b`  in  W  operand B; sampled only on the input handshake.
- `cin`  in  1  carry-in to nibble 0; sampled on the input handshake.
- `out_valid`  out  1  result available.
- `out_ready`  in  1  consumer accepts result.
- `sum`  out  W  registered result.
- `cout`  out  1  carry out of the MSB nibble.
- `ovf`  out  1  two's-complement overflow.

## Operation
- Internal adder: one `ripple_carry_adder` instance with ports `A`, `B`, `Cin`, `Sum`, `Cout`, all 4-bit except the carries. No other adder logic in the datapath.
- Three states: IDLE, RUN, DONE.
- IDLE:
  - `in_ready`=1.
  - On `in_valid & in_ready`: latch `a`, `b` and `cin` into the carry register; clear the nibble counter and working sum; go to RUN.
- RUN:
  - `in_ready`=0. Adder inputs are `A=a_q[4k+3:4k]`, `B=b_q[4k+3:4k]`, `Cin=carry_q`, where k is the counter.
  - Each cycle, write adder `Sum` into working-sum nibble k, load `carry_q <= Cout`, and increment k.
  - When k = NIBBLES-1, go to DONE and, at the same edge, load the outputs:
    - `sum <= ` completed working sum.
    - `cout <= Cout`.
    - `ovf <= (a_q[W-1]==b_q[W-1]) & (final sum[W-1] != a_q[W-1])`.
- DONE:
  - `out_valid`=1 and `in_ready`=0.
  - `sum`, `cout` and `ovf` hold stable until `out_valid & out_ready`, then go to IDLE.
- Output registers change only on entry to DONE. Between operations they keep the last completed result.
- `in_ready` is combinational from state (IDLE). `out_valid` is combinational from state (DONE), or an equivalent register.
- Arithmetic: result is `(a + b + cin) mod 2^W`; `cout` is bit W of the full sum. No truncation or sign extension in the inputs.
- `in_valid` is ignored outside IDLE; operands presented then are neither latched nor queued.

## Timing
- Reset state, asynchronous, while `rst_n`=0:
  - state IDLE; `in_ready`=1; `out_valid`=0.
  - `sum`=0, `cout`=0, `ovf`=0; counter, carry and operand registers = 0.
- Latency: if the input handshake occurs at edge E0, `out_valid` is 1 after edge E0+NIBBLES.
- Minimum spacing between input handshakes is NIBBLES+2 cycles, with `out_ready` held 1.
- NIBBLES=1: RUN lasts one cycle; same rules apply.
- Back-pressure: `out_ready`=0 holds DONE indefinitely with no output change.
- Simultaneous `in_valid` during the DONE→IDLE handshake edge: not accepted. Acceptance occurs at the first edge with state IDLE.
- Reset mid-RUN or mid-DONE: the operation is discarded, `out_valid` drops immediately, and no partial result reaches `sum`.
- After reset release, the first edge may accept operands.

## Test plan
- Reset: assert `rst_n`=0 mid-cycle → immediately `in_ready`=1, `out_valid`=0, `sum`=0x0000, `cout`=0, `ovf`=0 (NIBBLES=4 for all scenarios).
- Basic add: a=0x0003, b=0x0003, cin=0 → `sum`=0x0006, `cout`=0, `ovf`=0; `out_valid` rises exactly 4 cycles after acceptance.
- Carry ripple across slices:
  - a=0x0FFF, b=0x0001, cin=0 → `sum`=0x1000, `cout`=0.
  - a=0xFFFF, b=0x0000, cin=1 → `sum`=0x0000, `cout`=1, `ovf`=0.
- Overflow:
  - a=0x7FFF, b=0x0001, cin=0 → `sum`=0x8000, `cout`=0, `ovf`=1.
  - a=0x8000, b=0x8000, cin=0 → `sum`=0x0000, `cout`=1, `ovf`=1.
- Back-pressure: a=0x0005, b=0x0002, cin=1, `out_ready`=0 for 5 cycles → `out_valid`=1 with `sum`=0x0008 stable and `in_ready`=0. A second operand pair presented meanwhile is ignored. Raise `out_ready` → IDLE, and the next accepted op gives the correct result.
- Reset mid-RUN: accept a=0x1234, b=0x1111, assert `rst_n`=0 two cycles later → `out_valid` never rises and `sum` stays 0x0000. After release, a=0x000A, b=0x0001 → `sum`=0x000B.
